neurona_mac_secuencial: RTL
===========================

# neurona_mac_secuencial

Register bank and sequential multiply-accumulate engine for one perceptron neuron. It sits directly downstream of the register-write address decoder and consumes that decoder's 22 one-hot `EnableRegister` strobes and its `EnableStart` level. It holds 20 training coefficients, an offset and a 20-deep input delay line. On start it computes the weighted sum plus offset one product per cycle, then reports the result and a step-activation bit.

## Interface
- `DATA_W`, 16: width of coefficients, offset, inputs and `Resultado`; signed two's complement, Q(DATA_W-FRAC).FRAC.
- `FRAC`, 8: fractional bits of every DATA_W operand.
- `NUM_COEF`, 20: number of coefficients, which is also the delay-line depth. Fixed to match the 22-bit enable vector.
- `ACC_W`, 40: accumulator width. Must be ≥ 2·DATA_W + 5.

- `Clock`: in, 1. Single clock; all state updates on its rising edge.
- `Reset_n`: in, 1. Asynchronous, active-low reset.
- `DataIn`: in, DATA_W. Write data bus.
- `EnableRegister`: in, 22. Bit i<20 loads coefficient i, bit 20 loads the offset, bit 21 shifts `DataIn` into the input line.
- `EnableStart`: in, 1. Start request. It is a level that is not qualified by a write, so the block acts on its rising edge only.
- `Busy`: out, 1. High while a computation is in progress.
- `Done`: out, 1. One-cycle pulse when `Resultado` and `Salida` become valid.
- `Resultado`: out, DATA_W. Accumulator rescaled to Q format.
- `Salida`: out, 1. Step activation: 1 when the full accumulator is ≥ 0.

## Operation
- **Storage**
  - Coefficients `coef[0..19]`, `offset` and inputs `x[0..19]` are DATA_W registers.
  - An Entrada write (bit 21) sets `x[0]<=DataIn` and `x[i]<=x[i-1]`.
  - Several bits asserted together each act independently.
- **Writes while `Busy`=1:** all writes are ignored and the stored values are held.
- **Start detection:** registered `start_q`. A start occurs when `EnableStart & ~start_q` is sampled in IDLE. A start edge during `Busy` is dropped, not queued.
- **State machine**
  - IDLE → LOAD on a start.
  - LOAD: `acc <= sext(offset) << FRAC`; `idx <= 0`; go to MAC.
  - MAC: `acc <= acc + sext(coef[idx]*x[idx])`, where the product is signed 2·DATA_W. `idx++`. After idx = NUM_COEF-1, go to FIN.
  - FIN: register `Resultado` and `Salida`, pulse `Done`, go to IDLE.
- **Rescale:** `Resultado` takes `acc[FRAC+DATA_W-1:FRAC]`. Truncation, no rounding. See Configuration.
- **Activation:** `Salida = ~acc[ACC_W-1]`, computed from the full accumulator before rescale or saturation.
- **Output hold:** `Resultado` and `Salida` keep their value until the next FIN.
- **Reset (any time, including mid-computation):** all storage, `acc`, `idx` and `start_q` go to 0, state goes to IDLE, and all outputs go to 0. An aborted run produces no `Done`.

## Timing
- **Edge numbering:** edge 0 is the edge that samples the start.
- **State sequence:** edge 0 → LOAD; edge 1 → MAC at idx 0; edges 2..21 perform the 20 MACs; edge 22 performs FIN.
- **Outputs:** `Done`=1 for exactly the cycle after edge 22. `Busy`=1 from after edge 0 until edge 22, and is 0 during the `Done` cycle.
- **Latency:** 22 cycles from start to result.
- **Throughput:** a new start edge may be sampled in the `Done` cycle.
- **Write and start in the same IDLE cycle:** the write takes effect, and the computation uses the new value because LOAD reads storage one edge later.
- **Start held high:** exactly one run; a new run needs a low-then-high transition.
- **Reset values:** `Busy`=0, `Done`=0, `Resultado`=0, `Salida`=0.

## Configuration
- `NEURONA_SAT_EN` defined: `Resultado` saturates. If `acc >> FRAC` exceeds the DATA_W signed range, the output is 0x7FFF or 0x8000 (for DATA_W=16).
- `NEURONA_SAT_EN` undefined: plain truncation of `acc[FRAC+DATA_W-1:FRAC]`, which wraps on overflow.
- `Salida` is unaffected in both cases.

## Test plan
- **Reset:** `Reset_n` low mid-simulation → `Busy`=`Done`=`Salida`=0 and `Resultado`=0x0000 immediately, without waiting for a clock.
- **Unity weights:** all 20 coefficients 0x0100, 20 Entrada writes of 0x0100, offset 0, then start → `Done` after edge 22, `Resultado`=0x1400, `Salida`=1.
- **Negative offset:** coefficients 0, offset 0xF000, start → `Resultado`=0xF000, `Salida`=0.
- **Overflow:** coefficients and inputs all 0x7FFF, offset 0 → `Resultado`=0x7FFF with `NEURONA_SAT_EN` and 0xEC00 without; `Salida`=1 in both builds.
- **Start and write qualification:**
  - `EnableStart` held high 30 cycles → exactly one `Done`.
  - A second edge and a coefficient write issued during `Busy` → both ignored, and the next run's result is unchanged.
- **Reset mid-run:** assert `Reset_n` low at edge 10 of a run → no `Done`. After release, reload the registers and start → correct result at edge 22.

Source files
------------

// File: rtl/neurona_mac_secuencial.sv
// Perceptron neuron: coefficient/offset/input register bank plus a sequential
// MAC engine (one product per cycle). Optional output saturation: NEURONA_SAT_EN.
module neurona_mac_secuencial #(
  parameter int DATA_W   = 16,
  parameter int FRAC     = 8,
  parameter int NUM_COEF = 20,
  parameter int ACC_W    = 40
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [21:0]       EnableRegister,
  input  logic              EnableStart,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Resultado,
  output logic              Salida
);

  localparam int IDX_W = $clog2(NUM_COEF);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_FIN} state_t;

  state_t                    r_state, w_next;
  logic signed [DATA_W-1:0]  r_coef [NUM_COEF];
  logic signed [DATA_W-1:0]  r_x    [NUM_COEF];
  logic signed [DATA_W-1:0]  r_offset;
  logic signed [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_start_q;
  logic                      r_done;
  logic [DATA_W-1:0]         r_res;
  logic                      r_sal;

  logic                      w_idle;
  logic                      w_start;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]         w_res;

  assign w_idle  = (r_state == S_IDLE);
  // Start is an unqualified level: act only on its rising edge, and only in IDLE.
  assign w_start = EnableStart & ~r_start_q & w_idle;
  assign w_prod  = r_coef[r_idx] * r_x[r_idx];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NUM_COEF; i++) begin
        r_coef[i] <= '0;
        r_x[i]    <= '0;
      end
      r_offset <= '0;
    end else if (w_idle) begin
      for (int unsigned i = 0; i < NUM_COEF; i++)
        if (EnableRegister[i]) r_coef[i] <= DataIn;
      if (EnableRegister[20]) r_offset <= DataIn;
      if (EnableRegister[21]) begin
        r_x[0] <= DataIn;
        for (int unsigned i = 1; i < NUM_COEF; i++) r_x[i] <= r_x[i-1];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_LOAD;
      S_LOAD: w_next = S_MAC;
      S_MAC:  if (r_idx == IDX_W'(NUM_COEF-1)) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy      = ~w_idle;
    Done      = r_done;
    Resultado = r_res;
    Salida    = r_sal;
  end

`ifdef NEURONA_SAT_EN
  logic [ACC_W-FRAC-DATA_W:0] w_hi;
  assign w_hi  = r_acc[ACC_W-1:FRAC+DATA_W-1];
  // Representable only when every bit above the result MSB equals the sign.
  assign w_res = ((&w_hi) || !(|w_hi)) ? r_acc[FRAC+DATA_W-1:FRAC] :
                 r_acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                  {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign w_res = r_acc[FRAC+DATA_W-1:FRAC];
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_start_q <= 1'b0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_res     <= '0;
      r_sal     <= 1'b0;
    end else begin
      r_start_q <= EnableStart;
      r_done    <= (r_state == S_FIN);
      case (r_state)
        S_LOAD: begin
          r_acc <= {{(ACC_W-DATA_W-FRAC){r_offset[DATA_W-1]}}, r_offset, {FRAC{1'b0}}};
          r_idx <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
          r_idx <= r_idx + 1'b1;
        end
        S_FIN: begin
          r_res <= w_res;
          r_sal <= ~r_acc[ACC_W-1];
        end
        default: ;
      endcase
    end
  end

endmodule
